// File: rtl/snake_engine_param.sv
// Snake game core: segment array, 2-deep direction queue, growth and collision
// handling on a walled grid, plus a registered per-pixel classifier for the renderer.
module snake_engine_param #(
    parameter int GRID_W     = 40,
    parameter int GRID_H     = 30,
    parameter int CW         = 6,
    parameter int MAX_LEN    = 32,
    parameter int INIT_LEN   = 3,
    parameter int TICK_DIV   = 12_500_000,
    parameter int CELL_SHIFT = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [1:0]                   game_status,
    input  logic                         dir_valid,
    input  logic [1:0]                   dir_code,
    input  logic                         grow,
    input  logic                         die_flash,
    input  logic [11:0]                  pix_x,
    input  logic [11:0]                  pix_y,
    output logic [1:0]                   pix_class,
    output logic [CW-1:0]                head_x,
    output logic [CW-1:0]                head_y,
    output logic [$clog2(MAX_LEN+1)-1:0] length,
    output logic                         hit_wall,
    output logic                         hit_body,
    output logic                         full
);

    localparam int LW = $clog2(MAX_LEN + 1);
    localparam int TW = $clog2(TICK_DIV);
    localparam logic [LW-1:0] LEN_MAX   = LW'(MAX_LEN);
    localparam logic [LW-1:0] LEN_INIT  = LW'(INIT_LEN);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [CW-1:0] COL_LAST  = CW'(GRID_W - 1);
    localparam logic [CW-1:0] ROW_LAST  = CW'(GRID_H - 1);
    localparam logic [11:0]   PIX_COLS  = 12'(GRID_W);
    localparam logic [11:0]   PIX_ROWS  = 12'(GRID_H);
    localparam logic [1:0] DIR_UP = 2'b00, DIR_DOWN = 2'b01, DIR_LEFT = 2'b10, DIR_RIGHT = 2'b11;
    localparam logic [1:0] PC_NONE = 2'b00, PC_HEAD = 2'b01, PC_BODY = 2'b10, PC_WALL = 2'b11;

    function automatic logic [CW-1:0] init_x(int i);
        return (i < INIT_LEN) ? CW'(GRID_W / 4 - i) : '0;
    endfunction

    function automatic logic [CW-1:0] init_y(int i);
        return (i < INIT_LEN) ? CW'(GRID_H / 6) : '0;
    endfunction

    logic [TW-1:0] tick_cnt;
    logic [1:0]    dir, dq0, dq1, dq_cnt;
    logic [LW-1:0] len_r, pend;
    logic          grow_d;
    logic [CW-1:0] seg_x [MAX_LEN];
    logic [CW-1:0] seg_y [MAX_LEN];

    logic          restart, play, move, grow_edge;
    logic [1:0]    dir_p, dq0_p, dq1_p, dq_cnt_p, ref_dir;
    logic [1:0]    dir_n, dq0_n, dq1_n, dq_cnt_n;
    logic [CW-1:0] nx, ny;
    logic          wall_n, body_n, grow_now;
    logic [LW-1:0] len_n, pend_n, len_last;
    logic [11:0]   cx, cy;
    logic [1:0]    pix_n;

    assign restart   = (game_status == 2'b00);
    assign play      = (game_status == 2'b10);
    assign move      = play && (tick_cnt == TICK_LAST) && !hit_wall && !hit_body;
    assign grow_edge = grow && !grow_d && !restart;
    assign len_last  = len_r - LW'(1);

    // Pop happens first so that a request arriving on the move cycle sees the post-pop queue.
    always_comb begin
        dir_p    = dir;
        dq0_p    = dq0;
        dq1_p    = dq1;
        dq_cnt_p = dq_cnt;
        if (move && dq_cnt != 2'd0) begin
            dir_p    = dq0;
            dq0_p    = dq1;
            dq_cnt_p = dq_cnt - 2'd1;
        end
        ref_dir = (dq_cnt_p == 2'd0) ? dir_p : ((dq_cnt_p == 2'd1) ? dq0_p : dq1_p);
        dir_n    = dir_p;
        dq0_n    = dq0_p;
        dq1_n    = dq1_p;
        dq_cnt_n = dq_cnt_p;
        if (dir_valid && dir_code[1] != ref_dir[1] && dq_cnt_p != 2'd2) begin
            if (dq_cnt_p == 2'd0) dq0_n = dir_code;
            else                  dq1_n = dir_code;
            dq_cnt_n = dq_cnt_p + 2'd1;
        end
    end

    always_comb begin
        nx = seg_x[0];
        ny = seg_y[0];
        case (dir_p)
            DIR_UP:    ny = seg_y[0] - CW'(1);
            DIR_DOWN:  ny = seg_y[0] + CW'(1);
            DIR_LEFT:  nx = seg_x[0] - CW'(1);
            default:   nx = seg_x[0] + CW'(1);
        endcase
        wall_n = (nx == '0) || (nx == COL_LAST) || (ny == '0) || (ny == ROW_LAST);
        // The tail only counts as an obstacle if it is not about to vacate.
        body_n = 1'b0;
        for (int i = 1; i < MAX_LEN; i++) begin
            if (LW'(i) < len_r && (LW'(i) != len_last || pend != '0) &&
                seg_x[i] == nx && seg_y[i] == ny)
                body_n = 1'b1;
        end
        grow_now = move && !wall_n && !body_n && pend != '0 && len_r < LEN_MAX;
        len_n    = len_r + LW'(grow_now);
        pend_n   = pend - LW'(grow_now);
        if (grow_edge && pend_n < LEN_MAX - len_n) pend_n = pend_n + LW'(1);
        if (len_n == LEN_MAX) pend_n = '0;
    end

    always_comb begin
        cx    = pix_x >> CELL_SHIFT;
        cy    = pix_y >> CELL_SHIFT;
        pix_n = PC_NONE;
        if (cx < PIX_COLS && cy < PIX_ROWS) begin
            if (cx == '0 || cx == PIX_COLS - 12'd1 || cy == '0 || cy == PIX_ROWS - 12'd1) begin
                pix_n = PC_WALL;
            end else if (die_flash) begin
                if (cx == 12'(seg_x[0]) && cy == 12'(seg_y[0])) begin
                    pix_n = PC_HEAD;
                end else begin
                    for (int i = 1; i < MAX_LEN; i++) begin
                        if (LW'(i) < len_r && cx == 12'(seg_x[i]) && cy == 12'(seg_y[i]))
                            pix_n = PC_BODY;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tick_cnt  <= '0;
            dir       <= DIR_RIGHT;
            dq0       <= DIR_UP;
            dq1       <= DIR_UP;
            dq_cnt    <= 2'd0;
            len_r     <= LEN_INIT;
            pend      <= '0;
            grow_d    <= 1'b0;
            hit_wall  <= 1'b0;
            hit_body  <= 1'b0;
            full      <= 1'b0;
            pix_class <= PC_NONE;
            for (int i = 0; i < MAX_LEN; i++) begin
                seg_x[i] <= init_x(i);
                seg_y[i] <= init_y(i);
            end
        end else if (restart) begin
            tick_cnt  <= '0;
            dir       <= DIR_RIGHT;
            dq0       <= DIR_UP;
            dq1       <= DIR_UP;
            dq_cnt    <= 2'd0;
            len_r     <= LEN_INIT;
            pend      <= '0;
            grow_d    <= grow;
            hit_wall  <= 1'b0;
            hit_body  <= 1'b0;
            full      <= 1'b0;
            pix_class <= PC_NONE;
            for (int i = 0; i < MAX_LEN; i++) begin
                seg_x[i] <= init_x(i);
                seg_y[i] <= init_y(i);
            end
        end else begin
            grow_d <= grow;
            if (play) tick_cnt <= (tick_cnt == TICK_LAST) ? '0 : tick_cnt + TW'(1);
            dir    <= dir_n;
            dq0    <= dq0_n;
            dq1    <= dq1_n;
            dq_cnt <= dq_cnt_n;
            len_r  <= len_n;
            pend   <= pend_n;
            if (len_n == LEN_MAX) full <= 1'b1;
            if (move) begin
                if (wall_n) begin
                    hit_wall <= 1'b1;
                end else if (body_n) begin
                    hit_body <= 1'b1;
                end else begin
                    // Shifting every slot keeps the old tail in seg[len], ready for a grow.
                    for (int i = 1; i < MAX_LEN; i++) begin
                        seg_x[i] <= seg_x[i-1];
                        seg_y[i] <= seg_y[i-1];
                    end
                    seg_x[0] <= nx;
                    seg_y[0] <= ny;
                end
            end
            pix_class <= pix_n;
        end
    end

    assign head_x = seg_x[0];
    assign head_y = seg_y[0];
    assign length = len_r;

endmodule
